uart_mem_bridge: RTL
====================

// Module: uart_mem_bridge
// PURPOSE
//  Parametrised UART memory bridge: turns CPU load/store requests into byte frames for an external memory host.
//  Sits between the CPU memory port and a byte-level UART TX/RX pair.
//  Adds parametric address/data widths, a write ACK/NAK, a response timeout, bounded retry and an error flag.
// PARAMETERS
//  ADDR_W      32     address width; multiple of 8, 8..32
//  DATA_W      32     data width; multiple of 8, 8..64
//  TIMEOUT_CYC 100000 max idle cycles waiting for an RX byte; must be >=2
//  MAX_RETRY   2      retries after the first attempt (0 = no retry); must be <=7
//  ACK_BYTE    8'hA5  write-acknowledge byte; any other byte is a NAK
// PORTS
//  clk          in  1       clock; all logic on rising edge
//  reset        in  1       asynchronous, active-low reset
//  write_enable in  1       store request (level); wins over read_enable if both high
//  read_enable  in  1       load request (level)
//  address      in  ADDR_W  request address
//  writeData    in  DATA_W  store data
//  SizeLoad     in  3       load size code, sent in the header
//  MemWrite     in  2       store size code, sent in the header
//  readData     out DATA_W  load result, registered
//  mem_done     out 1       1-cycle completion pulse (success or error)
//  mem_err      out 1       valid with mem_done; 1 = retries exhausted
//  busy         out 1       high whenever state != IDLE
//  tx_data      out 8       byte to UART TX
//  tx_valid     out 1       byte valid; a byte transfers on tx_valid&tx_ready
//  tx_ready     in  1       UART TX can accept a byte
//  rx_data      in  8       byte from UART RX
//  rx_valid     in  1       1-cycle strobe, rx_data valid
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; readData, mem_done, mem_err, tx_valid and all counters = 0.
//  Abort: reset mid-transaction aborts the frame; no mem_done is issued.
//  Capture: in IDLE with an enable high, latch op, address, writeData, size code; clear retry count; go to HDR.
//   CPU inputs are don't-care until mem_done.
//  Header byte: {op(1=wr), retry_cnt[2:0], 1'b0, code[2:0]}; code = write ? {1'b0,MemWrite} : SizeLoad.
//  Byte order: address bytes (ADDR_W/8) and data bytes (DATA_W/8) go LSB byte first.
//  TX rule: tx_data stable while tx_valid is high; tx_valid drops only after the transfer cycle.
//   Byte counter advances only on tx_valid&tx_ready; back-to-back bytes allowed.
//  States:
//   IDLE  -> HDR on an enable.
//   HDR   -> ADDR after the header transfers.
//   ADDR  -> WDATA (write) or RDATA (read) after the last address byte.
//   WDATA -> WACK after the last data byte.
//   WACK  : rx_valid with rx_data==ACK_BYTE -> DONE. Other byte (NAK) or timeout -> RETRY.
//   RDATA : collect DATA_W/8 bytes, LSB first, into a shadow register; last byte -> DONE.
//           Timeout -> RETRY.
//   RETRY : retry_cnt<MAX_RETRY -> retry_cnt+1, HDR (full frame resent). Otherwise -> ERR.
//   DONE  : mem_done=1, mem_err=0; a read copies shadow to readData this cycle; -> IDLE.
//   ERR   : mem_done=1, mem_err=1; readData unchanged; -> IDLE.
//  Timeout: counter clears on entry to WACK/RDATA and on each rx_valid.
//   It fires when it reaches TIMEOUT_CYC-1 with no rx_valid.
//   rx_valid in the same cycle as the fire wins over the timeout.
//  rx_valid outside WACK/RDATA is ignored; its bytes are never buffered.
//  readData holds its last successful load value between transactions (not zeroed in IDLE).
//  Timing: mem_done comes 1 cycle after the final ACK/data byte strobe. New capture is allowed the cycle after DONE/ERR.
// TESTING
//  T1 write: ADDR_W=DATA_W=32, addr=0x1000_0004, wd=0xDEADBEEF, MemWrite=2, tx_ready=1, ACK 0xA5
//     -> TX 82 04 00 00 10 EF BE AD DE; mem_done=1, mem_err=0.
//  T2 read: SizeLoad=5, addr=0x20, RX bytes 78 56 34 12
//     -> TX 05 20 00 00 00; readData=0x12345678 one cycle after the 4th strobe; mem_done pulse.
//  T3 NAK then ACK, MAX_RETRY=2: reply 0x00 then 0xA5
//     -> second header = 0x92 (retry_cnt=1); success; exactly one mem_done.
//  T4 timeout, TIMEOUT_CYC=16: no RX on a read -> three frames sent, then mem_done&mem_err;
//     readData keeps its previous value.
//  T5 backpressure/priority: tx_ready toggling 1-0-1 and both enables high
//     -> write frame only; no byte dropped or duplicated.
//  T6 reset mid-RDATA after 2 bytes -> all outputs 0 immediately; next read completes normally.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
// Converts CPU load/store requests into byte frames on a UART TX/RX pair.
// A frame is a header byte, the address bytes and (for stores) the data
// bytes, all LSB byte first. Stores wait for an ACK byte. Loads collect
// DATA_W/8 reply bytes. A NAK or a silent link resends the whole frame up
// to MAX_RETRY times, after which the request completes with mem_err set.
module uart_mem_bridge #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          TIMEOUT_CYC = 100000,
  parameter int          MAX_RETRY   = 2,
  parameter logic [7:0]  ACK_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  input  logic [2:0]        SizeLoad,
  input  logic [1:0]        MemWrite,
  output logic [DATA_W-1:0] readData,
  output logic              mem_done,
  output logic              mem_err,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int CNT_W      = 4;
  localparam int TO_W       = $clog2(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_ADDR, S_WDATA, S_WACK, S_RDATA, S_RETRY, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic              r_op;        // 1 = store
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_code;
  logic [2:0]        r_retry;
  logic [CNT_W-1:0]  r_cnt;       // byte index within the current section
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_shadow;    // load bytes collected so far
  logic [DATA_W-1:0] r_read_data;
  logic              r_mem_done;
  logic              r_mem_err;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;

  logic              w_xfer;
  logic              w_to_fire;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_addr_last;
  logic              w_data_last;
  logic [7:0]        w_addr_byte_next;
  logic [7:0]        w_wdata_byte_next;
  logic [DATA_W-1:0] w_shadow_next;
  logic [2:0]        w_cap_code;
  logic [2:0]        w_retry_inc;

  function automatic logic [7:0] hdr_byte(input logic op, input logic [2:0] rc,
                                           input logic [2:0] code);
    return {op, rc, 1'b0, code};
  endfunction

  assign w_xfer            = r_tx_valid & tx_ready;
  assign w_to_fire         = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign w_cnt_inc         = r_cnt + CNT_W'(1);
  assign w_addr_last       = (r_cnt == CNT_W'(ADDR_BYTES - 1));
  assign w_data_last       = (r_cnt == CNT_W'(DATA_BYTES - 1));
  assign w_addr_byte_next  = 8'(r_addr >> {w_cnt_inc, 3'b000});
  assign w_wdata_byte_next = 8'(r_wdata >> {w_cnt_inc, 3'b000});
  // Shadow is cleared on RDATA entry, so OR-ing the new byte in is enough.
  assign w_shadow_next     = r_shadow | (DATA_W'(rx_data) << {r_cnt, 3'b000});
  assign w_cap_code        = write_enable ? {1'b0, MemWrite} : SizeLoad;
  assign w_retry_inc       = r_retry + 3'd1;

  assign readData = r_read_data;
  assign mem_done = r_mem_done;
  assign mem_err  = r_mem_err;
  assign busy     = (r_state != S_IDLE);
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

  // Transaction FSM: framing, reply collection, timeout, retry and completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_code      <= '0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_shadow    <= '0;
      r_read_data <= '0;
      r_mem_done  <= 1'b0;
      r_mem_err   <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge value of each register regardless of statement order.
      case (r_state)
        S_IDLE: begin
          if (write_enable || read_enable) begin
            r_op       <= write_enable;
            r_addr     <= address;
            r_wdata    <= writeData;
            r_code     <= w_cap_code;
            r_retry    <= '0;
            r_tx_data  <= hdr_byte(write_enable, 3'd0, w_cap_code);
            r_tx_valid <= 1'b1;
            r_state    <= S_HDR;
          end
        end

        S_HDR: begin
          if (w_xfer) begin
            r_cnt     <= '0;
            r_tx_data <= r_addr[7:0];
            r_state   <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (w_xfer) begin
            if (w_addr_last) begin
              r_cnt <= '0;
              if (r_op) begin
                r_tx_data <= r_wdata[7:0];
                r_state   <= S_WDATA;
              end else begin
                r_tx_valid <= 1'b0;
                r_to_cnt   <= '0;
                r_shadow   <= '0;
                r_state    <= S_RDATA;
              end
            end else begin
              r_cnt     <= w_cnt_inc;
              r_tx_data <= w_addr_byte_next;
            end
          end
        end

        S_WDATA: begin
          if (w_xfer) begin
            if (w_data_last) begin
              r_tx_valid <= 1'b0;
              r_to_cnt   <= '0;
              r_state    <= S_WACK;
            end else begin
              r_cnt     <= w_cnt_inc;
              r_tx_data <= w_wdata_byte_next;
            end
          end
        end

        S_WACK: begin
          if (rx_valid) begin
            r_to_cnt <= '0;
            if (rx_data == ACK_BYTE) begin
              r_mem_done <= 1'b1;
              r_mem_err  <= 1'b0;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_RETRY;
            end
          end else if (w_to_fire) begin
            r_state <= S_RETRY;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        S_RDATA: begin
          if (rx_valid) begin
            r_to_cnt <= '0;
            r_shadow <= w_shadow_next;
            if (w_data_last) begin
              r_read_data <= w_shadow_next;
              r_mem_done  <= 1'b1;
              r_mem_err   <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else if (w_to_fire) begin
            r_state <= S_RETRY;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        S_RETRY: begin
          if (r_retry < 3'(MAX_RETRY)) begin
            r_retry    <= w_retry_inc;
            r_tx_data  <= hdr_byte(r_op, w_retry_inc, r_code);
            r_tx_valid <= 1'b1;
            r_state    <= S_HDR;
          end else begin
            r_mem_done <= 1'b1;
            r_mem_err  <= 1'b1;
            r_state    <= S_ERR;
          end
        end

        S_DONE, S_ERR: begin
          r_mem_done <= 1'b0;
          r_mem_err  <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
